// File: rtl/stopwatch_buttons.sv
// Button conditioning for the stopwatch: synchronise and debounce pause/lap/view,
// then derive the pause level, a stretched lap request and one-hot lap view selects.
module stopwatch_buttons #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19,
    parameter int LAP_HOLD        = 500002
) (
    input  logic clk_50M,
    input  logic reset,
    input  logic btn_pause,
    input  logic btn_lap,
    input  logic btn_view,
    output logic pause,
    output logic lap_req,
    output logic lap1,
    output logic lap2,
    output logic lap3
);

    localparam int HOLD_W = $clog2(LAP_HOLD + 1);
    localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LAP_HOLD - 1);

    typedef enum logic {IDLE, HOLD} lap_state_t;
    typedef enum logic [1:0] {LIVE, L1, L2, L3} view_state_t;

    logic [2:0] raw;
    logic [2:0] press;

    assign raw = {btn_view, btn_lap, btn_pause};

    // Bit 0 = pause, bit 1 = lap, bit 2 = view; each channel is fully independent.
    for (genvar i = 0; i < 3; i++) begin : g_chan
        logic             s1;
        logic             s2;
        logic             stable;
        logic             stable_d;
        logic [CNT_W-1:0] count;

        // NOTE: sequential state uses <= so every flop samples pre-edge values; s1 -> s2 stays a real two-stage synchroniser.
        always_ff @(posedge clk_50M or posedge reset) begin
            if (reset) begin
                s1       <= 1'b0;
                s2       <= 1'b0;
                stable   <= 1'b0;
                stable_d <= 1'b0;
                count    <= '0;
            end else begin
                s1       <= raw[i];
                s2       <= s1;
                stable_d <= stable;
                if (s2 == stable) begin
                    count <= '0;
                end else if (count == DB_LAST) begin
                    stable <= s2;
                    count  <= '0;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end

        assign press[i] = stable & ~stable_d;
    end

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            pause <= 1'b0;
        end else if (press[0]) begin
            pause <= ~pause;
        end
    end

    lap_state_t        lap_state;
    logic [HOLD_W-1:0] hold_cnt;

    // Presses arriving while the request is held are dropped, not queued.
    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            lap_state <= IDLE;
            lap_req   <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            case (lap_state)
                IDLE: begin
                    if (press[1]) begin
                        lap_state <= HOLD;
                        lap_req   <= 1'b1;
                        hold_cnt  <= '0;
                    end
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        lap_state <= IDLE;
                        lap_req   <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    lap_state <= IDLE;
                    lap_req   <= 1'b0;
                end
            endcase
        end
    end

    view_state_t view_state;
    view_state_t view_next;

    // NOTE: always_comb gets a default assignment first so no path can infer a latch.
    always_comb begin
        view_next = view_state;
        case (view_state)
            LIVE:    view_next = L1;
            L1:      view_next = L2;
            L2:      view_next = L3;
            L3:      view_next = LIVE;
            default: view_next = LIVE;
        endcase
    end

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            view_state <= LIVE;
            lap1       <= 1'b0;
            lap2       <= 1'b0;
            lap3       <= 1'b0;
        end else if (press[2]) begin
            view_state <= view_next;
            lap1       <= (view_next == L1);
            lap2       <= (view_next == L2);
            lap3       <= (view_next == L3);
        end
    end

endmodule

// File: tb/tb_stopwatch_buttons.sv
// Directed bench for stopwatch_buttons with short debounce and hold times.
module tb_stopwatch_buttons;

    logic clk_50M = 1'b0;
    logic reset   = 1'b1;
    logic btn_pause = 1'b0;
    logic btn_lap   = 1'b0;
    logic btn_view  = 1'b0;
    logic pause, lap_req, lap1, lap2, lap3;

    int checks = 0;
    int errors = 0;

    stopwatch_buttons #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(3),
        .LAP_HOLD(10)
    ) dut (
        .clk_50M(clk_50M),
        .reset(reset),
        .btn_pause(btn_pause),
        .btn_lap(btn_lap),
        .btn_view(btn_view),
        .pause(pause),
        .lap_req(lap_req),
        .lap1(lap1),
        .lap2(lap2),
        .lap3(lap3)
    );

    always #10 clk_50M = ~clk_50M;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk_50M);
        #1;
    endtask

    // Count how many cycles lap_req stays high, starting from a cycle where it is high.
    task automatic measure_pulse(input string tag);
        int w;
        w = 1;
        for (int i = 0; i < 50 && lap_req; i++) begin
            tick(1);
            if (lap_req) w++;
        end
        check(tag, w, 10);
    endtask

    logic        bounce [5];
    logic [2:0]  view_exp [6];

    initial begin
        bounce   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        view_exp = '{3'b000, 3'b100, 3'b010, 3'b001, 3'b000, 3'b100};

        tick(3);
        check("reset_outputs", {pause, lap_req, lap1, lap2, lap3}, 5'b00000);
        reset = 1'b0;

        // Pause: two clean presses, each held 20 cycles then released.
        btn_pause = 1'b1;
        tick(6);  check("pause_press1_edge6", pause, 1'b0);
        tick(1);  check("pause_press1_edge7", pause, 1'b1);
        tick(13); btn_pause = 1'b0;
        tick(10); check("pause_release1", pause, 1'b1);
        btn_pause = 1'b1;
        tick(6);  check("pause_press2_edge6", pause, 1'b1);
        tick(1);  check("pause_press2_edge7", pause, 1'b0);
        tick(13); btn_pause = 1'b0;
        tick(10); check("pause_release2", pause, 1'b0);

        // Lap bounce then steady press.
        for (int k = 0; k < 5; k++) begin
            btn_lap = bounce[k];
            tick(1);
        end
        check("lap_bounce_quiet", lap_req, 1'b0);
        btn_lap = 1'b1;
        tick(6);  check("lap_bounce_edge6", lap_req, 1'b0);
        tick(1);  check("lap_bounce_edge7", lap_req, 1'b1);
        measure_pulse("lap_bounce_width");
        btn_lap = 1'b0;
        tick(12);

        // Second press debounced during HOLD is dropped.
        btn_lap = 1'b1;
        tick(4);  btn_lap = 1'b0;
        tick(2);  check("lap2_edge6", lap_req, 1'b0);
        tick(1);  check("lap2_edge7", lap_req, 1'b1);
        tick(1);  btn_lap = 1'b1;
        tick(8);  check("lap2_edge16_high", lap_req, 1'b1);
        tick(1);  check("lap2_edge17_fall", lap_req, 1'b0);
        tick(10); check("lap2_not_queued", lap_req, 1'b0);
        btn_lap = 1'b0;
        tick(12);

        // Third press after the pulse fell gives a fresh pulse.
        btn_lap = 1'b1;
        tick(6);  check("lap3_edge6", lap_req, 1'b0);
        tick(1);  check("lap3_edge7", lap_req, 1'b1);
        measure_pulse("lap3_width");
        btn_lap = 1'b0;
        tick(12);

        // View cycling through five presses.
        check("view_initial", {lap1, lap2, lap3}, view_exp[0]);
        for (int k = 1; k < 6; k++) begin
            btn_view = 1'b1;
            tick(6);  check($sformatf("view%0d_edge6", k), {lap1, lap2, lap3}, view_exp[k-1]);
            tick(1);  check($sformatf("view%0d_edge7", k), {lap1, lap2, lap3}, view_exp[k]);
            check($sformatf("view%0d_onehot", k), 32'($countones({lap1, lap2, lap3}) <= 1), 1);
            btn_view = 1'b0;
            tick(10);
        end

        // Pause and lap pressed together.
        btn_pause = 1'b1;
        btn_lap   = 1'b1;
        tick(6);  check("simul_edge6", {pause, lap_req}, 2'b00);
        tick(1);  check("simul_edge7", {pause, lap_req}, 2'b11);
        btn_pause = 1'b0;
        btn_lap   = 1'b0;
        tick(14);
        check("simul_after", {pause, lap_req, lap1, lap2, lap3}, 5'b10100);

        // Reset mid-HOLD and mid-debounce with lap still held.
        btn_lap = 1'b1;
        tick(7);  check("rst_lap_rise", lap_req, 1'b1);
        tick(2);  btn_view = 1'b1;
        tick(2);
        reset = 1'b1;
        #2;
        check("rst_async_clear", {pause, lap_req, lap1, lap2, lap3}, 5'b00000);
        btn_view = 1'b0;
        tick(3);
        check("rst_held", {pause, lap_req, lap1, lap2, lap3}, 5'b00000);
        reset = 1'b0;
        tick(6);  check("rst_release_edge6", lap_req, 1'b0);
        tick(1);  check("rst_release_edge7", {pause, lap_req, lap1, lap2, lap3}, 5'b01000);
        measure_pulse("rst_release_width");
        btn_lap = 1'b0;
        tick(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
